// File: rtl/memory_param.sv
// memory_param: single-port word memory with a power-up/reset clearing sweep.
// After rst the array is zeroed one word per cycle (busy high for DEPTH
// cycles), then reads (latency 1) and writes are serviced. Rejected requests
// (during the sweep, rd+wr collision, or address >= DEPTH) pulse err.
// Optional feature macro: MEMORY_PARAM_ACCESS_CNT_EN adds saturating
// rd_cnt/wr_cnt outputs counting accepted reads and writes.
module memory_param #(
  parameter int DW    = 8,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] din,
`ifdef MEMORY_PARAM_ACCESS_CNT_EN
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt,
`endif
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          err
);

  // Index width covers 0..DEPTH-1; the range check uses one extra bit so
  // DEPTH == 2**AW compares correctly.
  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] init_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic          req_s;
  logic          in_range_s;
  logic          rd_ok_s;
  logic          wr_ok_s;
  logic          bad_s;
  logic [IW-1:0] idx_s;

  // Request decode: accepted read/write only in IDLE, in range, no collision.
  always_comb begin
    req_s      = cen & (rd | wr);
    in_range_s = ({1'b0, address} < DEPTH_W);
    idx_s      = address[IW-1:0];
    rd_ok_s    = (state == IDLE) & cen & rd & ~wr & in_range_s;
    wr_ok_s    = (state == IDLE) & cen & wr & ~rd & in_range_s;
    bad_s      = req_s & ~(rd_ok_s | wr_ok_s);
  end

  // Storage array: sweep writes zero in INIT, accepted writes store din.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[init_ptr] <= '0;
      end else if (wr_ok_s) begin
        mem[idx_s] <= din;
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_ptr   <= '0;
      busy       <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= rd_ok_s;
      err        <= bad_s;
      if (rd_ok_s) begin
        dout <= mem[idx_s];
      end
      case (state)
        INIT: begin
          if (init_ptr == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            init_ptr <= '0;
          end else begin
            init_ptr <= init_ptr + IW'(1);
          end
        end
        IDLE: begin
          busy <= 1'b0;
        end
        default: begin
          state    <= INIT;
          busy     <= 1'b1;
          init_ptr <= '0;
        end
      endcase
    end
  end

`ifdef MEMORY_PARAM_ACCESS_CNT_EN
  // Saturating counters of accepted reads and writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= 16'h0000;
      wr_cnt <= 16'h0000;
    end else begin
      if (rd_ok_s && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (wr_ok_s && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/memory_param.md
MEMORY_PARAM -- requirements
Module: memory_param

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter AW, default 12, address width in bits.
REQ-003 Parameter DEPTH, default 4096, number of words; SHALL satisfy 1 <= DEPTH <= 2**AW and need not be a power of two.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 cen  input  1  chip enable, active-high; rd and wr are ignored while cen=0.
REQ-007 rd  input  1  read request, sampled at the clk edge.
REQ-008 wr  input  1  write request, sampled at the clk edge.
REQ-009 address  input  AW  word address.
REQ-010 din  input  DW  write data.
REQ-011 dout  output  DW  registered read data.
REQ-012 dout_valid  output  1  one-cycle pulse marking new dout.
REQ-013 busy  output  1  high while the initialisation sweep runs.
REQ-014 err  output  1  one-cycle pulse on any rejected request.

Function
REQ-015 The state machine SHALL have two states: INIT (clearing) and IDLE (servicing requests).
REQ-016 In INIT, the block SHALL write zero to location init_ptr each cycle, starting at init_ptr=0.
REQ-017 INIT SHALL end after init_ptr=DEPTH-1 is written; the state SHALL move to IDLE on the next edge, so busy is high for exactly DEPTH cycles after rst falls.
REQ-018 A request is active when cen=1 and (rd=1 or wr=1).
REQ-019 An active request while busy=1 SHALL be ignored and SHALL pulse err the next cycle.
REQ-020 An accepted write in IDLE (cen=1, wr=1, rd=0, address<DEPTH) SHALL store din at address on that edge.
REQ-021 An accepted read in IDLE (cen=1, rd=1, wr=0, address<DEPTH) SHALL drive mem[address] on dout with dout_valid=1 on the next cycle (latency 1).
REQ-022 A read of an address written on the previous edge SHALL return the new data.
REQ-023 cen=1 with rd=1 and wr=1 together SHALL perform no access and SHALL pulse err the next cycle.
REQ-024 An active request with address>=DEPTH SHALL perform no write, SHALL leave dout unchanged with dout_valid=0, and SHALL pulse err the next cycle.
REQ-025 dout SHALL hold its last value when no read is accepted.
REQ-026 dout_valid and err SHALL never be high in the same cycle.
REQ-027 Back-to-back accepted reads SHALL each produce one dout_valid pulse, with no bubbles.

Reset
REQ-028 While rst=1 at an edge: dout=0, dout_valid=0, err=0, busy=1, state=INIT, init_ptr=0.
REQ-029 Requests sampled while rst=1 SHALL be ignored and SHALL NOT raise err.
REQ-030 rst asserted during INIT SHALL restart the sweep from location 0.
REQ-031 rst asserted during IDLE SHALL re-clear the whole array, taking DEPTH cycles.

Configuration
REQ-032 Macro MEMORY_PARAM_ACCESS_CNT_EN SHALL add outputs rd_cnt[15:0] and wr_cnt[15:0].
REQ-033 With the macro defined, rd_cnt and wr_cnt SHALL count accepted reads and writes respectively.
REQ-034 With the macro defined, both counters SHALL saturate at 16'hFFFF and SHALL clear on rst.
REQ-035 Without the macro, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Release rst with DEPTH=16 -> busy high exactly 16 cycles; then a read of every address returns 0 with dout_valid one cycle later.
REQ-037 Write 8'hA5 to 12'h123, then on the next cycle read 12'h123 -> dout=8'hA5 with dout_valid=1 one cycle after the read.
REQ-038 cen=1, rd=1, wr=1, address=12'h010, din=8'h3C -> err pulse; a later read of 12'h010 returns 8'h00.
REQ-039 DEPTH=3000, write 8'hFF to 12'hBB8 -> err pulse, no write; a read of 12'hBB8 -> err, dout unchanged.
REQ-040 Write during busy, then assert rst at INIT cycle 5 -> err pulse for the write; sweep restarts with busy high for a further DEPTH cycles; memory all zero.
REQ-041 With MEMORY_PARAM_ACCESS_CNT_EN defined: 3 writes, 2 reads, 1 collision -> wr_cnt=3, rd_cnt=2; rst -> both counters 0.
